// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace buffer: run-state encoding, entry record and counter widths.
package wb_trace_pkg;

    localparam int RD_W   = 4;
    localparam int DATA_W = 32;
    localparam int REC_W  = RD_W + DATA_W;
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_e;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with registered head: a push into an empty FIFO is on the head next cycle.
// Head holds while not popped; a push while full is refused unless a pop frees the slot that cycle.
module wb_trace_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 36,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic          head_vld_o,
    output logic [W-1:0]  head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          head_vld_q, head_vld_d;
    logic [W-1:0]  head_dat_q, head_dat_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0) && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        head_vld_d = head_vld_q;
        head_dat_d = head_dat_q;
        if (clear_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            head_vld_d = 1'b0;
            head_dat_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d    = count_q + CW'(do_push) - CW'(do_pop);
            head_vld_d = (count_d != '0);
            // The new head is the incoming word when nothing older survives this edge.
            if (do_push && ((count_q - CW'(do_pop)) == '0)) begin
                head_dat_d = push_dat_i;
            end else if (count_d != '0) begin
                head_dat_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
        end
    end

    assign head_vld_o = head_vld_q;
    assign head_dat_o = head_dat_q;
    assign count_o    = count_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired writes in RUN into a FIFO read over valid/ready; a write at edge N is readable at N+1 if empty.
// Full drops are counted, or halt capture when STOP_ON_FULL=1; WB_TRACE_TS_EN adds the capture-cycle timestamp.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [RD_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [RD_W-1:0]          out_rd,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [1:0]               state_out
);

`ifdef WB_TRACE_TS_EN
    localparam int EW = TS_W + REC_W;
`else
    localparam int EW = REC_W;
`endif

    run_state_e        state_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;
    logic              capture, pop, full, drop;
    logic [EW-1:0]     push_dat, head_dat;
    wb_rec_t           push_rec, head_rec;

    assign push_rec.rd   = wb_rd;
    assign push_rec.data = wb_data;

    // stop and clear both veto the write presented on their own edge.
    assign capture = wb_valid && (state_q == ST_RUN) && !stop && !clear;
    assign pop     = out_valid && out_ready;
    assign drop    = capture && full && !pop;

`ifdef WB_TRACE_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign push_dat = {ts_q, push_rec};
    assign head_rec = head_dat[REC_W-1:0];
    assign out_ts   = head_dat[EW-1 -: TS_W];
`else
    assign push_dat = push_rec;
    assign head_rec = head_dat;
    assign out_ts   = '0;
`endif

    wb_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (capture),
        .push_dat_i (push_dat),
        .pop_i      (out_ready),
        .clear_i    (clear),
        .head_vld_o (out_valid),
        .head_dat_o (head_dat),
        .count_o    (count),
        .full_o     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !stop) state_q <= ST_RUN;
                ST_RUN:  if (stop || ((STOP_ON_FULL != 0) && drop)) state_q <= ST_HALT;
                ST_HALT: if (start && !stop) state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    assign out_rd    = head_rec.rd;
    assign out_data  = head_rec.data;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed table, hand sequences, and randomized traffic against a queue model.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
`ifdef WB_TRACE_TS_EN
    localparam logic [15:0] TS_MASK = 16'hFFFF;
`else
    localparam logic [15:0] TS_MASK = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset, wb_valid, start, stop, clear, out_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, overflow;
    logic [3:0]  out_rd;
    logic [31:0] out_data;
    logic [15:0] out_ts, drop_cnt;
    logic [4:0]  count;
    logic [1:0]  state_out;

    logic        b_wv, b_start, b_stop, b_clear, b_rdy;
    logic [3:0]  b_rd;
    logic [31:0] b_data;
    logic        b_out_valid, b_overflow;
    logic [3:0]  b_out_rd;
    logic [31:0] b_out_data;
    logic [15:0] b_out_ts, b_drop_cnt;
    logic [4:0]  b_count;
    logic [1:0]  b_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .TS_W(16), .STOP_ON_FULL(0)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .start(start), .stop(stop), .clear(clear), .out_ready(out_ready),
        .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data), .out_ts(out_ts),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .state_out(state_out)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .TS_W(16), .STOP_ON_FULL(1)) dut_sof (
        .clk(clk), .reset(reset), .wb_valid(b_wv), .wb_rd(b_rd), .wb_data(b_data),
        .start(b_start), .stop(b_stop), .clear(b_clear), .out_ready(b_rdy),
        .out_valid(b_out_valid), .out_rd(b_out_rd), .out_data(b_out_data), .out_ts(b_out_ts),
        .count(b_count), .overflow(b_overflow), .drop_cnt(b_drop_cnt), .state_out(b_state)
    );

    // Reference model: a plain queue of captured writes plus counters.
    typedef struct {
        int          ts;
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_state, m_drop, m_ts;
    bit   m_ovf;

    typedef struct {
        bit          wv;
        logic [3:0]  rd;
        logic [31:0] data;
        bit          st, sp, cl, rdy;
        bit          e_vld;
        logic [3:0]  e_rd;
        logic [31:0] e_data;
        int          e_ts, e_cnt, e_state;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(bit wv, logic [3:0] rd, logic [31:0] d, bit st, bit sp, bit cl,
                                bit rdy, bit ev, logic [3:0] erd, logic [31:0] ed, int ets,
                                int ecnt, int est);
        vec_t v;
        v.wv = wv; v.rd = rd; v.data = d; v.st = st; v.sp = sp; v.cl = cl; v.rdy = rdy;
        v.e_vld = ev; v.e_rd = erd; v.e_data = ed; v.e_ts = ets; v.e_cnt = ecnt; v.e_state = est;
        return v;
    endfunction

    function automatic logic [15:0] exp_ts(int t);
        return 16'(t) & TS_MASK;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   pop, cap;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_state = 0; m_drop = 0; m_ovf = 0; m_ts = 0;
            return;
        end
        pop = (mq.size() > 0) && out_ready;
        cap = wb_valid && (m_state == 1) && !stop && !clear;
        if (clear) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    e.ts = m_ts; e.rd = wb_rd; e.data = wb_data;
                    mq.push_back(e);
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end
            end
        end
        if (stop && m_state == 1)                 m_state = 2;
        else if (start && !stop && m_state != 1)  m_state = 1;
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic model_check();
        chk("m.count", count, mq.size());
        chk("m.out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("m.out_rd", out_rd, mq[0].rd);
            chk("m.out_data", out_data, mq[0].data);
            chk("m.out_ts", out_ts, exp_ts(mq[0].ts));
        end
        chk("m.state", state_out, m_state);
        chk("m.drop_cnt", drop_cnt, m_drop);
        chk("m.overflow", overflow, m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic idle_in();
        wb_valid = 0; wb_rd = '0; wb_data = '0; start = 0; stop = 0; clear = 0; out_ready = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out_rd"}, out_rd, 0);
        chk({tag, ".out_data"}, out_data, 0);
        chk({tag, ".out_ts"}, out_ts, 0);
        chk({tag, ".count"}, count, 0);
        chk({tag, ".overflow"}, overflow, 0);
        chk({tag, ".drop_cnt"}, drop_cnt, 0);
        chk({tag, ".state"}, state_out, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        b_wv = 0; b_rd = '0; b_data = '0; b_start = 0; b_stop = 0; b_clear = 0; b_rdy = 0;
        m_state = 0; m_drop = 0; m_ovf = 0; m_ts = 0;

        // Directed table; row i is applied in the cycle whose timestamp is i.
        vt[0] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 10; i++) vt[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[10] = mk(1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 1, 1, 4'd3, 32'hDEADBEEF, 10, 1, 1);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vt[12] = mk(1, 4'd5, 32'h5555, 0, 0, 0, 0, 1, 4'd5, 32'h5555, 12, 1, 1);
        vt[13] = mk(1, 4'd6, 32'h6666, 0, 0, 0, 0, 1, 4'd5, 32'h5555, 12, 2, 1);
        vt[14] = mk(1, 4'd7, 32'h7777, 0, 1, 0, 0, 1, 4'd5, 32'h5555, 12, 2, 2);
        vt[15] = mk(1, 4'd8, 32'h8888, 0, 0, 0, 0, 1, 4'd5, 32'h5555, 12, 2, 2);
        vt[16] = mk(0, 0, 0, 1, 0, 0, 0, 1, 4'd5, 32'h5555, 12, 2, 1);
        vt[17] = mk(1, 4'd9, 32'h9999, 0, 0, 0, 1, 1, 4'd6, 32'h6666, 13, 2, 1);
        vt[18] = mk(1, 4'd10, 32'hAAAA, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        reset = 1;
        cycle();
        chk_reset_vals("rst");
        reset = 0;

        for (int i = 0; i < 20; i++) begin
            wb_valid = vt[i].wv; wb_rd = vt[i].rd; wb_data = vt[i].data;
            start = vt[i].st; stop = vt[i].sp; clear = vt[i].cl; out_ready = vt[i].rdy;
            cycle();
            chk($sformatf("t%0d.state", i), state_out, vt[i].e_state);
            chk($sformatf("t%0d.count", i), count, vt[i].e_cnt);
            chk($sformatf("t%0d.valid", i), out_valid, vt[i].e_vld);
            chk($sformatf("t%0d.drop", i), drop_cnt, 0);
            if (vt[i].e_vld) begin
                chk($sformatf("t%0d.rd", i), out_rd, vt[i].e_rd);
                chk($sformatf("t%0d.data", i), out_data, vt[i].e_data);
                chk($sformatf("t%0d.ts", i), out_ts, exp_ts(vt[i].e_ts));
            end
        end
        idle_in();

        // Fill and drop, then push+pop while full, then drain in order.
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1; wb_rd = 4'(i); wb_data = 32'hA000_0000 + 32'(i);
            cycle();
        end
        chk("fill.count", count, 16);
        chk("fill.drop", drop_cnt, 4);
        chk("fill.ovf", overflow, 1);
        wb_data = 32'hB000_0001; wb_rd = 4'hF; out_ready = 1;
        cycle();
        chk("pp.count", count, 16);
        chk("pp.drop", drop_cnt, 4);
        wb_valid = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d.data", k), out_data,
                (k < 15) ? 32'hA000_0000 + 32'(k + 1) : 32'hB000_0001);
            cycle();
        end
        chk("drain.count", count, 0);
        idle_in();

        // clear + stop together with a push.
        clear = 1;
        cycle();
        clear = 0; wb_valid = 1;
        for (int i = 0; i < 3; i++) begin wb_data = 32'(i); cycle(); end
        clear = 1; stop = 1;
        cycle();
        chk("prio.count", count, 0);
        chk("prio.state", state_out, 2);
        chk("prio.drop", drop_cnt, 0);
        idle_in();
        start = 1;
        cycle();
        start = 0;

        // Reset with five entries queued; timestamp restarts.
        wb_valid = 1;
        for (int i = 0; i < 5; i++) begin wb_rd = 4'(i); wb_data = 32'h50 + 32'(i); cycle(); end
        chk("mid.count_pre", count, 5);
        reset = 1;
        cycle();
        chk_reset_vals("mid");
        reset = 0; idle_in(); start = 1;
        cycle();
        start = 0; wb_valid = 1; wb_rd = 4'd2; wb_data = 32'h1234_5678;
        cycle();
        chk("mid.valid", out_valid, 1);
        chk("mid.ts", out_ts, exp_ts(1));
        chk("mid.data", out_data, 32'h1234_5678);
        idle_in(); out_ready = 1;
        cycle();
        idle_in();

        // Stop-on-full instance.
        b_start = 1;
        cycle();
        b_start = 0;
        chk("sof.run", b_state, 1);
        b_wv = 1;
        for (int i = 0; i < 17; i++) begin
            b_rd = 4'(i); b_data = 32'hC000_0000 + 32'(i);
            cycle();
            if (i == 15) begin
                chk("sof.cnt16", b_count, 16);
                chk("sof.state16", b_state, 1);
                chk("sof.drop16", b_drop_cnt, 0);
            end
        end
        chk("sof.halt", b_state, 2);
        chk("sof.drop", b_drop_cnt, 1);
        chk("sof.ovf", b_overflow, 1);
        chk("sof.count", b_count, 16);
        for (int i = 0; i < 3; i++) cycle();
        chk("sof.count_after", b_count, 16);
        chk("sof.drop_after", b_drop_cnt, 1);
        b_wv = 0; b_start = 1;
        cycle();
        b_start = 0;
        chk("sof.restart", b_state, 1);
        chk("sof.head", b_out_data, 32'hC000_0000);
        b_clear = 1;
        cycle();
        b_clear = 0;
        chk("sof.clear", b_count, 0);

        // Randomized traffic against the model.
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) rdy_pct = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 90 : 50);
                wb_valid  = ($urandom_range(0, 99) < 70);
                wb_rd     = 4'($urandom);
                wb_data   = $urandom;
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                start     = ($urandom_range(0, 99) < 5);
                stop      = ($urandom_range(0, 99) < 2);
                clear     = ($urandom_range(0, 99) < 1);
                reset     = ($urandom_range(0, 999) < 2);
                cycle();
            end
        end
        idle_in();
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Debug capture block that sits directly downstream of the `tiny_risc` core's writeback outputs (`data_out`, `rd_out`, `wb_out`). It records every retired register write as a timestamped entry in a small FIFO and presents the entries on a valid/ready read port. A debug host or bench drains that port, so the architectural write stream is available without probing internal hierarchy. Capture is gated by a three-state run controller.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `TS_W`, 16: timestamp width in bits.
- `STOP_ON_FULL`, 0: 0 = drop new writes while full and count them; 1 = enter HALT when full.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  connects to core `wb_out`; a write retires this cycle.
- `wb_rd`  in  4  connects to core `rd_out`.
- `wb_data`  in  32  connects to core `data_out`.
- `start`  in  1  pulse; moves IDLE or HALT to RUN.
- `stop`  in  1  pulse; moves RUN to HALT.
- `clear`  in  1  pulse; flushes the FIFO and zeroes `overflow`/`drop_cnt`; does not change state.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_valid`  out  1  head entry is valid.
- `out_rd`  out  4  head entry register index.
- `out_data`  out  32  head entry data.
- `out_ts`  out  TS_W  head entry timestamp.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; at least one write was dropped.
- `drop_cnt`  out  16  number of dropped writes; saturates at 0xFFFF.
- `state_out`  out  2  IDLE=0, RUN=1, HALT=2.

## Operation
- Entry format is {ts, rd, data}. The entry is captured when `wb_valid` is high and the state is RUN.
- Push when not full: the entry is written at that edge.
- Push when full with `STOP_ON_FULL`=0: the entry is dropped, `drop_cnt` increments and `overflow` is set.
- Push when full with `STOP_ON_FULL`=1: the entry is dropped and the state goes to HALT at the same edge. `drop_cnt`/`overflow` still record the drop.
- Pop happens when `out_valid` and `out_ready` are both high.
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted; `count` is unchanged.
- Push and pop in the same cycle while empty: there is no pop. The push lands, `out_valid` rises the next cycle, and the push does not count as a drop.
- State transitions:
  - IDLE to RUN on `start`.
  - RUN to HALT on `stop` or on the full condition when `STOP_ON_FULL`=1.
  - HALT to RUN on `start`; FIFO contents are kept.
  - Priority within a cycle: `reset` > `clear` > `stop` > `start`.
  - `clear` in the same cycle as a push: the FIFO ends empty and the push is discarded without counting as a drop.
- Reads are allowed in every state.
- Timestamp counter increments every cycle after reset in all states and wraps from 2^TS_W−1 to 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is taken from `count`.

## Timing
- Reset values: `out_valid`=0, `out_rd`=0, `out_data`=0, `out_ts`=0, `count`=0, `overflow`=0, `drop_cnt`=0, `state_out`=IDLE, timestamp=0, pointers=0.
- A write presented at edge N is visible on the read port from cycle N+1 if the FIFO was empty at N. Otherwise it is visible after the earlier entries drain.
- Output fields are registered. They hold stable while `out_valid`=1 and `out_ready`=0.
- `start` at edge N: a `wb_valid` at edge N+1 is the first one captured.
- `stop` at edge N: a `wb_valid` at edge N is not captured.
- A reset mid-stream empties the FIFO at that edge. The next cycle shows the reset values.

## Configuration
- `WB_TRACE_TS_EN` defined: the timestamp counter exists and `out_ts` carries the capture cycle.
- `WB_TRACE_TS_EN` undefined: no counter and no ts field in storage; `out_ts` is driven 0. The port list is unchanged.

## Structure
- Shared package `wb_trace_pkg` holds:
  - state encodings IDLE/RUN/HALT;
  - the entry struct/width constants (`RD_W`=4, `DATA_W`=32);
  - the `drop_cnt` width.
- One sub-module, `wb_trace_fifo`: a synchronous FIFO with push/pop/clear, registered head and `count`.
- The top level holds the run FSM, the timestamp counter, and the drop accounting.

## Test plan
- Basic capture: reset, `start`, then push rd=3/0xDEADBEEF at cycle 10 with `out_ready`=1. Expect `out_valid` at cycle 11 with rd=3, data=0xDEADBEEF, ts=10.
- Fill and drop: DEPTH=16, `STOP_ON_FULL`=0, `out_ready`=0, 20 pushes. Expect `count`=16, `drop_cnt`=4, `overflow`=1. On drain, the 16 oldest entries come out in order.
- Stop-on-full: `STOP_ON_FULL`=1, 17 pushes. Expect `state_out`=HALT at the 17th edge and `drop_cnt`=1. Further pushes are ignored with no count change. A `start` returns to RUN.
- Simultaneous push/pop when full: expect `count` to stay 16, order preserved, and no drop.
- Control priority: `clear` and `stop` in the same cycle as a push. Expect `count`=0, state HALT, `drop_cnt` unchanged.
- Reset mid-stream: assert `reset` with 5 entries queued. Expect every output at its reset value the next cycle and ts restarting at 0.
